// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the core datapath control inputs.
// Optional retire counter port enabled by defining CORE_SEQ_RETIRE_CNT_EN.
module core_sequencer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned ALU_CMD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [15:0]          imem_data,
  output logic                 reg_wr_en,
  output logic [11:0]          operands,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 dst_in_sel,
  output logic                 busy,
`ifdef CORE_SEQ_RETIRE_CNT_EN
  output logic [15:0]          retire_cnt,
`endif
  output logic                 halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  localparam logic [3:0] OpLdi  = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      opcode;
  logic [PC_W-1:0] jmp_target;
  logic            start_ok;

  assign opcode     = ir_q[15:12];
  assign jmp_target = PC_W'(ir_q[7:0]);
  assign start_ok   = start && ((state_q == StIdle) || (state_q == StHalt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imem_req   = 1'b0;
    reg_wr_en  = 1'b0;
    dst_in_sel = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start_ok) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + PC_W'(1);
        if (opcode <= OpLdi) begin
          reg_wr_en  = 1'b1;
          dst_in_sel = (opcode == OpLdi);
        end else if (opcode == OpJmp) begin
          pc_d = jmp_target;
        end else if (opcode == OpHalt) begin
          pc_d    = pc_q;
          state_d = StHalt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ir only changes on entry to EXEC, so decoding it directly holds the last values elsewhere.
  always_comb begin
    alu_cmd = '0;
    if (opcode <= 4'hB) alu_cmd = ALU_CMD_W'(opcode);
  end

  assign operands  = ir_q[11:0];
  assign imem_addr = pc_q;
  assign busy      = (state_q == StFetch) || (state_q == StExec);
  assign halted    = (state_q == StHalt);

`ifdef CORE_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (start_ok) begin
      retire_cnt_q <= '0;
    end else if (state_q == StExec) begin
      retire_cnt_q <= retire_cnt_q + 16'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: vector table, scoreboard-backed memory responder,
// and directed sequences for reset, jump/wrap and (if enabled) the retire counter.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        reg_wr_en;
  logic [11:0] operands;
  logic [3:0]  alu_cmd;
  logic        dst_in_sel;
  logic        busy;
  logic        halted;
`ifdef CORE_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  core_sequencer #(
    .PC_W     (8),
    .ALU_CMD_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .reg_wr_en (reg_wr_en),
    .operands  (operands),
    .alu_cmd   (alu_cmd),
    .dst_in_sel(dst_in_sel),
    .busy      (busy),
`ifdef CORE_SEQ_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       sel;
    logic       chk_alu;
    logic [3:0] alu;
    logic [11:0] ops;
    logic [7:0] next;
    logic       halt;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    int          delay;
    logic        wr;
    logic        sel;
    logic        chk_alu;
    logic [3:0]  alu;
    logic [11:0] ops;
    logic [7:0]  next;
    logic        halt;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] mem [256];
  exp_t        sb [$];
  logic [7:0]  fetch_log [$];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  logic        start_nxt = 1'b0;
  logic        exp_valid = 1'b0;
  logic [7:0]  exp_addr = 8'h00;
  logic        prev_wr = 1'b0;
  vec_t        vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins, input logic [7:0] pc);
    exp_t e;
    logic [3:0] op;
    op        = ins[15:12];
    e.wr      = 1'b0;
    e.sel     = 1'b0;
    e.chk_alu = 1'b0;
    e.alu     = 4'h0;
    e.ops     = ins[11:0];
    e.next    = pc + 8'd1;
    e.halt    = 1'b0;
    if (op <= 4'hB) begin
      e.wr = 1'b1; e.chk_alu = 1'b1; e.alu = op;
    end else if (op == 4'hC) begin
      e.wr = 1'b1; e.sel = 1'b1; e.chk_alu = 1'b1;
    end else if (op == 4'hD) begin
      e.next = ins[7:0];
    end else if (op == 4'hF) begin
      e.next = pc; e.halt = 1'b1;
    end
    return e;
  endfunction

  // One clock: check outputs and drive inputs on the falling edge, return just after rising.
  task automatic cycle();
    exp_t e;
    logic in_exec;
    @(negedge clk);
    in_exec = busy && !imem_req;
    if (in_exec) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_underflow: got EXEC, expected no EXEC");
      end else begin
        e = sb.pop_front();
        check("exec_wr", 32'(reg_wr_en), 32'(e.wr));
        check("exec_sel", 32'(dst_in_sel), 32'(e.sel));
        check("exec_ops", 32'(operands), 32'(e.ops));
        if (e.chk_alu) check("exec_alu", 32'(alu_cmd), 32'(e.alu));
        exp_addr = e.next;
      end
    end else begin
      check("idle_wr", 32'(reg_wr_en), 32'd0);
      check("idle_sel", 32'(dst_in_sel), 32'd0);
    end
    check("wr_pulse", 32'(prev_wr & reg_wr_en), 32'd0);
    prev_wr = reg_wr_en;
    start = start_nxt;
    if (start_nxt && !busy) begin
      exp_addr  = 8'h00;
      exp_valid = 1'b1;
      sb.delete();
    end
    start_nxt = 1'b0;
    if (imem_req) begin
      if (exp_valid) check("fetch_addr", 32'(imem_addr), 32'(exp_addr));
      if (wait_cnt >= ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        sb.push_back(model(imem_data, imem_addr));
        fetch_log.push_back(imem_addr);
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        wait_cnt++;
      end
    end else begin
      imem_ack  = stray_ack;
      imem_data = 16'hC777;
      wait_cnt  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_halt(input int max);
    int i;
    i = 0;
    while (!halted && i < max) begin
      cycle();
      i++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic clear_model();
    sb.delete();
    exp_valid = 1'b0;
    wait_cnt  = 0;
    imem_ack  = 1'b0;
    prev_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    vecs[0] = '{16'h3123, 3, 1'b1, 1'b0, 1'b1, 4'h3, 12'h123, 8'h01, 1'b0};
    vecs[1] = '{16'hB0FF, 1, 1'b1, 1'b0, 1'b1, 4'hB, 12'h0FF, 8'h01, 1'b0};
    vecs[2] = '{16'hC205, 0, 1'b1, 1'b1, 1'b1, 4'h0, 12'h205, 8'h01, 1'b0};
    vecs[3] = '{16'h0000, 0, 1'b1, 1'b0, 1'b1, 4'h0, 12'h000, 8'h01, 1'b0};
    vecs[4] = '{16'hD0F0, 2, 1'b0, 1'b0, 1'b0, 4'h0, 12'h0F0, 8'hF0, 1'b0};
    vecs[5] = '{16'hDA05, 0, 1'b0, 1'b0, 1'b0, 4'h0, 12'hA05, 8'h05, 1'b0};
    vecs[6] = '{16'hE000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 8'h01, 1'b0};
    vecs[7] = '{16'hF000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 8'h00, 1'b1};

    // Reset state
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_ops", 32'(operands), 32'd0);
    check("rst_alu", 32'(alu_cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
    check("rst_retire", 32'(retire_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // LDI then HALT, ack in the first FETCH cycle: halted 4 cycles after start
    mem[0] = 16'hC205;
    mem[1] = 16'hF000;
    ack_delay = 0;
    start_nxt = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("halt_early", 32'(halted), 32'd0);
    cycle();
    check("halt_at_4", 32'(halted), 32'd1);
    check("halt_pc", 32'(imem_addr), 32'd1);

    // Vector table; each run starts from HALT
    foreach (vecs[v]) begin
      mem[0]    = vecs[v].instr;
      ack_delay = vecs[v].delay;
      start_nxt = 1'b1;
      cycle();
      k = 0;
      while (!(busy && !imem_req) && k < 10) begin
        cycle();
        k++;
      end
      check("vec_latency", 32'(k), 32'(vecs[v].delay + 1));
      check("vec_wr", 32'(reg_wr_en), 32'(vecs[v].wr));
      check("vec_sel", 32'(dst_in_sel), 32'(vecs[v].sel));
      check("vec_ops", 32'(operands), 32'(vecs[v].ops));
      if (vecs[v].chk_alu) check("vec_alu", 32'(alu_cmd), 32'(vecs[v].alu));
      cycle();
      if (vecs[v].halt) begin
        check("vec_halt", 32'(halted), 32'd1);
      end else begin
        check("vec_next_req", 32'(imem_req), 32'd1);
        check("vec_next_addr", 32'(imem_addr), 32'(vecs[v].next));
      end
      ack_delay = 0;
      run_until_halt(20);
    end

    // Jump chain and pc wrap: 00 -> 10 -> F0 -> FF (NOP) -> 00 ...
    mem[8'h00] = 16'hD010;
    mem[8'h10] = 16'hD0F0;
    mem[8'hF0] = 16'hD0FF;
    mem[8'hFF] = 16'hE000;
    fetch_log.delete();
    start_nxt = 1'b1;
    cycle();
    for (int i = 0; i < 11; i++) cycle();
    check("jmp_log_len", 32'(fetch_log.size() >= 5), 32'd1);
    if (fetch_log.size() >= 5) begin
      check("jmp_f0", 32'(fetch_log[0]), 32'h00);
      check("jmp_f1", 32'(fetch_log[1]), 32'h10);
      check("jmp_f2", 32'(fetch_log[2]), 32'hF0);
      check("jmp_f3", 32'(fetch_log[3]), 32'hFF);
      check("jmp_wrap", 32'(fetch_log[4]), 32'h00);
    end
    // start while busy is ignored; the scoreboard keeps tracking the loop
    k = 0;
    while (!imem_req && k < 4) begin
      cycle();
      k++;
    end
    start_nxt = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("busy_start_busy", 32'(busy), 32'd1);
    check("busy_start_halt", 32'(halted), 32'd0);

    // Asynchronous reset mid-FETCH, then a stray ack while idle
    ack_delay = 2;
    k = 0;
    while (!imem_req && k < 6) begin
      cycle();
      k++;
    end
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", 32'(imem_addr), 32'd0);
    clear_model();
    cycle();
    rst_n = 1'b1;
    stray_ack = 1'b1;
    cycle();
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_halted", 32'(halted), 32'd0);
      check("post_rst_req", 32'(imem_req), 32'd0);
    end

    // JMP to its own address loops indefinitely
    mem[0] = 16'hD000;
    ack_delay = 0;
    start_nxt = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    check("self_jmp_busy", 32'(busy), 32'd1);
    check("self_jmp_addr", 32'(imem_addr), 32'd0);

`ifdef CORE_SEQ_RETIRE_CNT_EN
    #2 rst_n = 1'b0;
    #1 clear_model();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) mem[i] = 16'hE000;
    mem[5] = 16'hF000;
    start_nxt = 1'b1;
    cycle();
    run_until_halt(40);
    check("retire_cnt", 32'(retire_cnt), 32'd6);
    start_nxt = 1'b1;
    cycle();
    check("retire_clr", 32'(retire_cnt), 32'd0);
    run_until_halt(40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
